alu_result_collector: RTL
=========================

Name: alu_result_collector

Overview:
- Downstream stage of the 16-bit ALU top. Consumes the four registered unit outputs (arithmetic, logic, compare, shift) and the carry and one-hot unit flags.
- Selects the active unit's result and tags it with the unit code and carry bit.
- Buffers results in a 4-entry FIFO and presents them to the consumer (register-file writeback) over a valid/ready handshake.
- Detects malformed flag patterns and lost results with sticky error bits.

Parameters:
- WIDTH, 16, data width of every ALU result bus and of Out_Data.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- CNT_W, 3, width of Count; equals log2(DEPTH)+1.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- In_Valid  input  1  the ALU outputs this cycle hold a result the controller wants kept.
- Arith_OUT  input  WIDTH  arithmetic unit result.
- Logic_OUT  input  WIDTH  logic unit result.
- CMP_OUT  input  WIDTH  compare unit result.
- SHIFT_OUT  input  WIDTH  shift unit result.
- Carry_OUT  input  1  arithmetic carry.
- Arith_Flag  input  1  arithmetic unit active.
- Logic_Flag  input  1  logic unit active.
- CMP_Flag  input  1  compare unit active.
- SHIFT_Flag  input  1  shift unit active.
- Out_Ready  input  1  consumer accepts the head entry.
- Clear_Err  input  1  synchronous clear of both sticky error bits.
- Out_Valid  output  1  FIFO is non-empty; head entry is on the output ports.
- Out_Data  output  WIDTH  head result.
- Out_Unit  output  2  head unit code: 0 arith, 1 logic, 2 cmp, 3 shift.
- Out_Carry  output  1  head carry bit; always 0 for non-arith entries.
- Count  output  CNT_W  current occupancy, 0..DEPTH.
- Flag_Err  output  1  sticky: In_Valid arrived with zero or more than one flag set.
- Overflow  output  1  sticky: a valid result was dropped because the FIFO was full.

Behaviour:
- Reset (RST low, asynchronous): FIFO empties; read/write pointers go to 0. Outputs: Count=0, Out_Valid=0, Out_Data=0, Out_Unit=0, Out_Carry=0, Flag_Err=0, Overflow=0. Reset mid-operation discards all buffered entries; nothing is replayed.
- Push request: In_Valid=1 and exactly one flag is high.
  - Entry = {unit code, carry, selected result}.
  - Carry is Carry_OUT only when Arith_Flag is high; otherwise 0.
- Flag check: In_Valid=1 with zero flags, or two or more flags, sets Flag_Err and pushes nothing.
- In_Valid=0: flags and buses are ignored.
- Pop: Out_Valid=1 and Out_Ready=1 on a rising edge. The head is removed; the next entry appears on the outputs the following cycle.
- Output timing:
  - Out_* are driven from registered FIFO storage through the read pointer, so there is no combinational path from the ALU inputs to the outputs.
  - Push-to-Out_Valid latency is 1 cycle: a push into an empty FIFO at edge N gives Out_Valid=1 after edge N.
  - When empty, Out_Data/Out_Unit/Out_Carry hold their last value.
- Full: Count=DEPTH.
  - A push request with no pop in the same cycle is dropped and sets Overflow.
  - A push request together with a pop in the same cycle is accepted; Count stays at DEPTH and Overflow is not set.
- Empty: Out_Ready is ignored; Count stays 0 and does not underflow.
- Simultaneous push and pop when non-empty and non-full: Count unchanged; pointers both advance.
- Pointers: DEPTH-modulo, wrap from DEPTH-1 to 0. Count is tracked explicitly.
- Sticky bits:
  - Flag_Err and Overflow set the cycle after the offending edge and stay high until Clear_Err=1 or reset.
  - If Clear_Err and a new error occur in the same cycle, set wins; the bit stays 1.

Decomposition:
- Shared package alu_pkg:
  - unit code constants UNIT_ARITH=2'd0, UNIT_LOGIC=2'd1, UNIT_CMP=2'd2, UNIT_SHIFT=2'd3;
  - ENTRY_W = WIDTH+3;
  - the ALU_FUN encodings, shared with the ALU top.
- One sub-module, alu_res_fifo: a generic synchronous FIFO (data width, depth, push/pop, full/empty, count, async active-low reset).
- The collector holds the select/flag-check logic, the entry packing and the sticky error registers.

Test Plan:
- Addition: A=14, B=7 gives Arith_OUT=0x0015, Arith_Flag=1, Carry_OUT=0; In_Valid for 1 cycle -> next cycle Out_Valid=1, Out_Data=0x0015, Out_Unit=0, Out_Carry=0, Count=1; Out_Ready=1 -> Count=0, Out_Valid=0.
- Fill and drop: with Out_Ready=0, push logic 0x0006, logic 0x000F, cmp 0x0001, shift 0x0018 -> Count=4; a fifth push of cmp 0x0002 -> Overflow=1, Count=4; drain -> outputs appear in order with Out_Unit 1,1,2,3 and no 0x0002.
- Full with simultaneous push/pop: at Count=4 assert Out_Ready=1 and push shift 0x0038 -> Overflow stays 0, Count=4, and 0x0038 is the last entry drained.
- Flag errors: In_Valid with Arith_Flag=Logic_Flag=1 -> Flag_Err=1, Count unchanged; then In_Valid with no flags -> still 1; Clear_Err for 1 cycle -> Flag_Err=0; Clear_Err together with a bad push -> Flag_Err remains 1.
- Carry masking: Carry_OUT=1 with SHIFT_Flag=1 -> Out_Carry=0; Carry_OUT=1 with Arith_Flag=1 and Arith_OUT=0x0000 -> Out_Carry=1, Out_Data=0x0000.
- Reset mid-operation: with Count=3 and Overflow=1, pull RST low between edges -> immediately Count=0, Out_Valid=0, Overflow=0, Out_Data=0; after release, one push gives Count=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg: unit codes, entry sizing and ALU_FUN encodings shared with the ALU top.
// Revision: 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_LOGIC = 2'd1;
  localparam logic [1:0] UNIT_CMP   = 2'd2;
  localparam logic [1:0] UNIT_SHIFT = 2'd3;

  localparam int WIDTH_DEF = 16;
  localparam int ENTRY_W   = WIDTH_DEF + 3;

  localparam logic [3:0] ALU_FUN_ADD  = 4'b0000;
  localparam logic [3:0] ALU_FUN_SUB  = 4'b0001;
  localparam logic [3:0] ALU_FUN_MUL  = 4'b0010;
  localparam logic [3:0] ALU_FUN_DIV  = 4'b0011;
  localparam logic [3:0] ALU_FUN_AND  = 4'b0100;
  localparam logic [3:0] ALU_FUN_OR   = 4'b0101;
  localparam logic [3:0] ALU_FUN_NAND = 4'b0110;
  localparam logic [3:0] ALU_FUN_NOR  = 4'b0111;
  localparam logic [3:0] ALU_FUN_XOR  = 4'b1000;
  localparam logic [3:0] ALU_FUN_XNOR = 4'b1001;
  localparam logic [3:0] ALU_FUN_CMP  = 4'b1010;
  localparam logic [3:0] ALU_FUN_GT   = 4'b1011;
  localparam logic [3:0] ALU_FUN_LT   = 4'b1100;
  localparam logic [3:0] ALU_FUN_SHR  = 4'b1101;
  localparam logic [3:0] ALU_FUN_SHL  = 4'b1110;

  // Entry layout, MSB first: {unit[1:0], carry, data[width-1:0]}.
  function automatic int entry_width(input int width);
    return width + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_collector_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_result_collector_if: ALU-side inputs and writeback-side outputs of the collector.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface alu_result_collector_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 3
);
  logic             In_Valid;
  logic [WIDTH-1:0] Arith_OUT;
  logic [WIDTH-1:0] Logic_OUT;
  logic [WIDTH-1:0] CMP_OUT;
  logic [WIDTH-1:0] SHIFT_OUT;
  logic             Carry_OUT;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             SHIFT_Flag;
  logic             Out_Ready;
  logic             Clear_Err;
  logic             Out_Valid;
  logic [WIDTH-1:0] Out_Data;
  logic [1:0]       Out_Unit;
  logic             Out_Carry;
  logic [CNT_W-1:0] Count;
  logic             Flag_Err;
  logic             Overflow;

  modport master (
    output In_Valid, Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT, Carry_OUT,
           Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag, Out_Ready, Clear_Err,
    input  Out_Valid, Out_Data, Out_Unit, Out_Carry, Count, Flag_Err, Overflow
  );

  modport slave (
    input  In_Valid, Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT, Carry_OUT,
           Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag, Out_Ready, Clear_Err,
    output Out_Valid, Out_Data, Out_Unit, Out_Carry, Count, Flag_Err, Overflow
  );
endinterface
`default_nettype wire

// File: rtl/alu_res_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_res_fifo: synchronous FIFO with explicit count; push accepted when full only alongside a pop.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_res_fifo #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              push,
  input  wire logic              pop,
  input  wire logic [DATA_W-1:0] wdata,
  output logic      [DATA_W-1:0] rdata,
  output logic                   full,
  output logic                   empty,
  output logic      [CNT_W-1:0]  count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;
  logic [PTR_W-1:0]  rd_idx;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // When empty the last popped slot (one behind rd_ptr) is shown so the outputs hold.
  assign rd_idx = empty ? (rd_ptr_q - PTR_W'(1)) : rd_ptr_q;
  assign rdata  = mem_q[rd_idx];
  assign count  = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (do_push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_result_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_result_collector: tags the active ALU unit result, queues it for writeback, flags errors.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input wire logic Clk,
  input wire logic RST,
  alu_result_collector_if.slave bus
);
  localparam int EW = entry_width(WIDTH);

  logic [2:0]       flag_cnt;
  logic             push_req, bad_flags, pop;
  logic             fifo_full, fifo_empty;
  logic [1:0]       sel_unit;
  logic [WIDTH-1:0] sel_data;
  logic             sel_carry;
  logic [EW-1:0]    entry, head;
  logic             flag_err_q, flag_err_d;
  logic             overflow_q, overflow_d;

  assign flag_cnt = {2'b0, bus.Arith_Flag} + {2'b0, bus.Logic_Flag}
                  + {2'b0, bus.CMP_Flag}   + {2'b0, bus.SHIFT_Flag};
  assign push_req  = bus.In_Valid && (flag_cnt == 3'd1);
  assign bad_flags = bus.In_Valid && (flag_cnt != 3'd1);
  assign pop       = bus.Out_Ready && !fifo_empty;

  // Only consulted on a push, where exactly one flag is high; arith is the fallthrough.
  always_comb begin
    sel_unit  = UNIT_ARITH;
    sel_data  = bus.Arith_OUT;
    sel_carry = bus.Carry_OUT;
    if (bus.Logic_Flag) begin
      sel_unit  = UNIT_LOGIC;
      sel_data  = bus.Logic_OUT;
      sel_carry = 1'b0;
    end else if (bus.CMP_Flag) begin
      sel_unit  = UNIT_CMP;
      sel_data  = bus.CMP_OUT;
      sel_carry = 1'b0;
    end else if (bus.SHIFT_Flag) begin
      sel_unit  = UNIT_SHIFT;
      sel_data  = bus.SHIFT_OUT;
      sel_carry = 1'b0;
    end
  end

  assign entry = {sel_unit, sel_carry, sel_data};

  alu_res_fifo #(
    .DATA_W (EW),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (RST),
    .push  (push_req),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.Count)
  );

  // Set takes priority over clear.
  always_comb begin
    flag_err_d = bad_flags || (flag_err_q && !bus.Clear_Err);
    overflow_d = (push_req && fifo_full && !pop) || (overflow_q && !bus.Clear_Err);
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      flag_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      flag_err_q <= flag_err_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.Out_Valid = !fifo_empty;
  assign bus.Out_Data  = head[WIDTH-1:0];
  assign bus.Out_Carry = head[WIDTH];
  assign bus.Out_Unit  = head[WIDTH+2:WIDTH+1];
  assign bus.Flag_Err  = flag_err_q;
  assign bus.Overflow  = overflow_q;
endmodule
`default_nettype wire
